// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing checker: recovers pixel coordinates from H_SYNC/V_SYNC,
// validates line/frame timing against nominal values and tracks timing lock.
module vga_sync_decoder #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC_W    = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC_W    = 2,
  parameter int V_BACK      = 33,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       H_SYNC,
  input  logic       V_SYNC,
  output logic [9:0] X_Axis,
  output logic [9:0] Y_Axis,
  output logic       Video_On,
  output logic       Locked,
  output logic       Timing_Err,
  output logic [7:0] Err_Count
);

  localparam logic [10:0] H_TOTAL = 11'(H_VISIBLE + H_FRONT + H_SYNC_W + H_BACK);
  localparam logic [10:0] V_TOTAL = 11'(V_VISIBLE + V_FRONT + V_SYNC_W + V_BACK);
  localparam logic [10:0] HSW     = 11'(H_SYNC_W);
  localparam logic [9:0]  VSW     = 10'(V_SYNC_W);
  localparam logic [9:0]  X_START = 10'(H_SYNC_W + H_BACK);
  localparam logic [9:0]  X_END   = 10'(H_SYNC_W + H_BACK + H_VISIBLE);
  localparam logic [9:0]  Y_START = 10'(V_SYNC_W + V_BACK);
  localparam logic [9:0]  Y_END   = 10'(V_SYNC_W + V_BACK + V_VISIBLE);
  localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);
  localparam logic [9:0]  CNT_MAX = 10'd1023;
  localparam logic [9:0]  WD_PRE  = 10'd1022;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t     state;
  logic       hs1, hs2, vs1, vs2;
  logic       hfall, hrise, vfall, vrise;
  logic [9:0] h_cnt, v_line;
  logic [3:0] good_cnt;
  logic       frame_bad;
  logic       armed, line_err, hsw_err, frame_err, vsw_err, wd_err, viol;
  logic       in_x, in_y;

  assign hfall = hs2 & ~hs1;
  assign hrise = ~hs2 & hs1;
  assign vfall = vs2 & ~vs1;
  assign vrise = ~vs2 & vs1;

  // Two-stage samplers idle high so reset release never fakes a sync edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs1 <= 1'b1;
      hs2 <= 1'b1;
      vs1 <= 1'b1;
      vs2 <= 1'b1;
    end else begin
      hs1 <= H_SYNC;
      hs2 <= hs1;
      vs1 <= V_SYNC;
      vs2 <= vs1;
    end
  end

  // Pixel and line counters; vfall restarts the frame even if hfall coincides
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt  <= 10'd0;
      v_line <= 10'd0;
    end else begin
      if (hfall)
        h_cnt <= 10'd0;
      else if (h_cnt != CNT_MAX)
        h_cnt <= h_cnt + 10'd1;
      if (vfall)
        v_line <= 10'd0;
      else if (hfall && v_line != CNT_MAX)
        v_line <= v_line + 10'd1;
    end
  end

  // Timing checks; the watchdog fires once, on the cycle h_cnt climbs to its ceiling
  always_comb begin
    armed     = (state != SEARCH);
    line_err  = armed & hfall & (({1'b0, h_cnt} + 11'd1) != H_TOTAL);
    hsw_err   = armed & hrise & (({1'b0, h_cnt} + 11'd1) != HSW);
    frame_err = armed & vfall & (({1'b0, v_line} + {10'd0, hfall}) != V_TOTAL);
    vsw_err   = armed & vrise & (v_line != VSW);
    wd_err    = (h_cnt == WD_PRE) & ~hfall;
    viol      = line_err | hsw_err | frame_err | vsw_err | wd_err;
  end

  // Error pulse and saturating error counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Timing_Err <= 1'b0;
      Err_Count  <= 8'd0;
    end else begin
      Timing_Err <= viol;
      if (viol && Err_Count != 8'hFF)
        Err_Count <= Err_Count + 8'd1;
    end
  end

  // Lock FSM; a violation on the completing vfall still marks that frame bad
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEARCH;
      good_cnt  <= 4'd0;
      frame_bad <= 1'b0;
      Locked    <= 1'b0;
    end else begin
      if (vfall)
        frame_bad <= 1'b0;
      else if (viol)
        frame_bad <= 1'b1;
      if (wd_err) begin
        state    <= SEARCH;
        good_cnt <= 4'd0;
        Locked   <= 1'b0;
      end else begin
        case (state)
          SEARCH: begin
            if (vfall) begin
              state    <= TRACK;
              good_cnt <= 4'd0;
            end
          end
          TRACK: begin
            if (vfall) begin
              if (frame_bad || viol) begin
                good_cnt <= 4'd0;
              end else if ((good_cnt + 4'd1) == LOCK_N) begin
                state    <= LOCKED;
                good_cnt <= good_cnt + 4'd1;
                Locked   <= 1'b1;
              end else begin
                good_cnt <= good_cnt + 4'd1;
              end
            end
          end
          LOCKED: begin
            if (viol) begin
              state    <= TRACK;
              good_cnt <= 4'd0;
              Locked   <= 1'b0;
            end
          end
          default: begin
            state    <= SEARCH;
            good_cnt <= 4'd0;
            Locked   <= 1'b0;
          end
        endcase
      end
    end
  end

  // Coordinate decode straight from the registered counters
  always_comb begin
    in_x     = (h_cnt >= X_START) && (h_cnt < X_END);
    in_y     = (v_line >= Y_START) && (v_line < Y_END);
    Video_On = Locked & in_x & in_y;
    if (Video_On) begin
      X_Axis = h_cnt - X_START;
      Y_Axis = v_line - Y_START;
    end else begin
      X_Axis = 10'd0;
      Y_Axis = 10'd0;
    end
  end

endmodule
